// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

   localparam int          FETCH_PC_W        = 32;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_PC_W-1:0] pc;
      logic [31:0]           instruction;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory-side and decode-side signals of the fetch unit; master = fetch unit.
interface instruction_fetch_if #(
   parameter int PC_WIDTH = 32
);
   logic [PC_WIDTH-1:0] imem_addr;
   logic [31:0]         imem_instruction;
   logic                redirect;
   logic [PC_WIDTH-1:0] redirect_pc;
   logic                if_valid;
   logic                if_ready;
   logic [31:0]         if_instruction;
   logic [PC_WIDTH-1:0] if_pc;
   logic                halted;

   modport master (
      output imem_addr,
      input  imem_instruction,
      input  redirect,
      input  redirect_pc,
      output if_valid,
      input  if_ready,
      output if_instruction,
      output if_pc,
      output halted
   );

   modport slave (
      input  imem_addr,
      output imem_instruction,
      output redirect,
      output redirect_pc,
      input  if_valid,
      output if_ready,
      input  if_instruction,
      input  if_pc,
      input  halted
   );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// DEPTH-entry fetch buffer with flush; the head entry is held in its own register.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  fetch_entry_t           push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic                   valid_o,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     head_q, head_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_next;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign rd_next = rd_ptr_q + 1'b1;

   // Next head comes from storage if more than one entry remains, else from the incoming push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_d = rd_next;
         count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(do_pop);
         if (do_pop) begin
            if (count_q > (PTR_W+1)'(1)) head_d = mem_q[rd_next];
            else if (push_i)             head_d = push_data_i;
         end else if (count_q == '0 && push_i) begin
            head_d = push_data_i;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign valid_o = (count_q != '0);
   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC register, BOOT/RUN/HALT control and redirect handling around the fetch buffer.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
   parameter int                  DEPTH     = 2,
   parameter logic [31:0]         HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   instruction_fetch_if.master fetch_bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                push, pop, flush, can_accept, head_valid;
   logic [CNT_W-1:0]    count;
   fetch_entry_t        push_entry, head;

   assign pop        = head_valid && fetch_bus.if_ready;
   assign can_accept = (count < CNT_W'(DEPTH)) || pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (fetch_bus.redirect)
               state_d = ST_RUN;
            else if (can_accept && fetch_bus.imem_instruction == HALT_WORD)
               state_d = ST_HALT;
         end
         ST_HALT: if (fetch_bus.redirect) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   // A redirect outranks everything except BOOT, where it is dropped.
   always_comb begin
      flush = fetch_bus.redirect && (state_q != ST_BOOT);
      push  = (state_q == ST_RUN) && !fetch_bus.redirect && can_accept
              && (fetch_bus.imem_instruction != HALT_WORD);
      pc_d  = pc_q;
      if (flush)     pc_d = fetch_bus.redirect_pc;
      else if (push) pc_d = pc_q + 1'b1;
   end

   assign push_entry.pc          = FETCH_PC_W'(pc_q);
   assign push_entry.instruction = fetch_bus.imem_instruction;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (flush),
      .valid_o     (head_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign fetch_bus.imem_addr      = pc_q;
   assign fetch_bus.if_valid       = head_valid;
   assign fetch_bus.if_instruction = head.instruction;
   assign fetch_bus.if_pc          = PC_WIDTH'(head.pc);
   assign fetch_bus.halted         = (state_q == ST_HALT);

endmodule
